// File: rtl/n1_dsp_arb_pkg.sv
// -----------------------------------------------------------------------------
// n1_dsp_arb_pkg
// Shared types for the N1 DSP arbiter: requester identifiers, the operand
// bundle a requester presents to the DSP cell, and the in-flight tag carried
// down the result pipeline.
// Optional feature macro used by this slice: N1_DSP_ARB_LOCK_EN.
// -----------------------------------------------------------------------------
package n1_dsp_arb_pkg;

    // Requester identity; the encoding doubles as the round-robin pointer.
    typedef enum logic {
        ALU  = 1'b0,
        PAGU = 1'b1
    } req_id_t;

    // Everything the DSP cell needs for one operation.
    typedef struct packed {
        logic        sub_add_b;
        logic        smul_umul_b;
        logic [15:0] add_op0;
        logic [15:0] add_op1;
        logic [15:0] mul_op0;
        logic [15:0] mul_op1;
    } dsp_req_t;

    // One in-flight operation: is it real, and who gets the result.
    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } tag_t;

    localparam int MAX_DSP_LAT = 4;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == ALU) ? PAGU : ALU;
    endfunction

endpackage

// File: rtl/n1_dsp_arb_if.sv
// -----------------------------------------------------------------------------
// n1_dsp_arb_if
// Bundles the requester side (ALU, PAGU) and the DSP-wrapper side of the
// arbiter. Signal names keep the arbiter-relative _i/_o suffixes.
//   slave  : the arbiter's view (requests/operands/DSP results in,
//            grants/acks/results/DSP operands out)
//   master : the surrounding core + DSP wrapper view (mirror image)
// lock_i exists only when N1_DSP_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
interface n1_dsp_arb_if;

    // Requester 0: ALU
    logic        alu_req_i;
    logic        alu_gnt_o;
    logic        alu_sub_add_b_i;
    logic        alu_smul_umul_b_i;
    logic [15:0] alu_add_op0_i;
    logic [15:0] alu_add_op1_i;
    logic [15:0] alu_mul_op0_i;
    logic [15:0] alu_mul_op1_i;
    logic        alu_ack_o;

    // Requester 1: PAGU
    logic        pagu_req_i;
    logic        pagu_gnt_o;
    logic        pagu_sub_add_b_i;
    logic        pagu_smul_umul_b_i;
    logic [15:0] pagu_add_op0_i;
    logic [15:0] pagu_add_op1_i;
    logic [15:0] pagu_mul_op0_i;
    logic [15:0] pagu_mul_op1_i;
    logic        pagu_ack_o;

    // Shared results back to the requesters
    logic [31:0] arb2req_add_res_o;
    logic [31:0] arb2req_mul_res_o;

    // DSP cell side
    logic        arb2dsp_sub_add_b_o;
    logic        arb2dsp_smul_umul_b_o;
    logic [15:0] arb2dsp_add_op0_o;
    logic [15:0] arb2dsp_add_op1_o;
    logic [15:0] arb2dsp_mul_op0_o;
    logic [15:0] arb2dsp_mul_op1_o;
    logic [31:0] dsp2arb_add_res_i;
    logic [31:0] dsp2arb_mul_res_i;

`ifdef N1_DSP_ARB_LOCK_EN
    logic        lock_i;
`endif

    modport slave (
        input  alu_req_i, alu_sub_add_b_i, alu_smul_umul_b_i,
        input  alu_add_op0_i, alu_add_op1_i, alu_mul_op0_i, alu_mul_op1_i,
        input  pagu_req_i, pagu_sub_add_b_i, pagu_smul_umul_b_i,
        input  pagu_add_op0_i, pagu_add_op1_i, pagu_mul_op0_i, pagu_mul_op1_i,
        input  dsp2arb_add_res_i, dsp2arb_mul_res_i,
`ifdef N1_DSP_ARB_LOCK_EN
        input  lock_i,
`endif
        output alu_gnt_o, alu_ack_o, pagu_gnt_o, pagu_ack_o,
        output arb2req_add_res_o, arb2req_mul_res_o,
        output arb2dsp_sub_add_b_o, arb2dsp_smul_umul_b_o,
        output arb2dsp_add_op0_o, arb2dsp_add_op1_o,
        output arb2dsp_mul_op0_o, arb2dsp_mul_op1_o
    );

    modport master (
        output alu_req_i, alu_sub_add_b_i, alu_smul_umul_b_i,
        output alu_add_op0_i, alu_add_op1_i, alu_mul_op0_i, alu_mul_op1_i,
        output pagu_req_i, pagu_sub_add_b_i, pagu_smul_umul_b_i,
        output pagu_add_op0_i, pagu_add_op1_i, pagu_mul_op0_i, pagu_mul_op1_i,
        output dsp2arb_add_res_i, dsp2arb_mul_res_i,
`ifdef N1_DSP_ARB_LOCK_EN
        output lock_i,
`endif
        input  alu_gnt_o, alu_ack_o, pagu_gnt_o, pagu_ack_o,
        input  arb2req_add_res_o, arb2req_mul_res_o,
        input  arb2dsp_sub_add_b_o, arb2dsp_smul_umul_b_o,
        input  arb2dsp_add_op0_o, arb2dsp_add_op1_o,
        input  arb2dsp_mul_op0_o, arb2dsp_mul_op1_o
    );

endinterface

// File: rtl/n1_dsp_arb_tagpipe.sv
// -----------------------------------------------------------------------------
// n1_dsp_arb_tagpipe
// DSP_LAT-deep shift register of {valid, owner} tags that shadows the DSP
// pipeline. The tag leaving the last stage marks the cycle in which the DSP
// result belongs to its owner, and produces that owner's one-cycle ack.
//   clk_i       : clock
//   sync_rst_i  : synchronous active-high reset, drops every in-flight tag
//   issue_tag_i : tag of the operation granted this cycle (valid=0 if none)
//   alu_ack_o   : ALU result valid this cycle
//   pagu_ack_o  : PAGU result valid this cycle
// DSP_LAT outside 1..MAX_DSP_LAT is clamped into that range.
// -----------------------------------------------------------------------------
module n1_dsp_arb_tagpipe
    import n1_dsp_arb_pkg::*;
#(
    parameter int DSP_LAT = 1
) (
    input  logic clk_i,
    input  logic sync_rst_i,
    input  tag_t issue_tag_i,
    output logic alu_ack_o,
    output logic pagu_ack_o
);

    localparam int LAT = (DSP_LAT < 1)           ? 1 :
                         (DSP_LAT > MAX_DSP_LAT) ? MAX_DSP_LAT : DSP_LAT;

    tag_t stage_q [LAT];
    tag_t out_tag;

    // NOTE: sequential state is written with non-blocking assignments so every
    // stage samples its neighbour's pre-edge value and the shift is order-free.
    // NOTE: this small tag array is reset in full because stale valid bits
    // would fire spurious acks; wide data storage would normally skip reset.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= issue_tag_i;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_tag = stage_q[LAT-1];

    // Acks are suppressed while reset is held so nothing leaks out of a
    // pipeline that is being flushed.
    assign alu_ack_o  = out_tag.valid && !sync_rst_i && (out_tag.owner == ALU);
    assign pagu_ack_o = out_tag.valid && !sync_rst_i && (out_tag.owner == PAGU);

endmodule

// File: rtl/n1_dsp_arb.sv
// -----------------------------------------------------------------------------
// n1_dsp_arb
// Shares the single DSP cell (add/sub + multiply) between the ALU
// (requester 0) and the PAGU (requester 1). Grants are combinational in the
// request cycle, the winner's operands drive the DSP, and the result comes
// back DSP_LAT cycles later with a one-cycle ack to the issuing requester.
//   clk_i      : clock
//   sync_rst_i : synchronous active-high reset
//   bus        : n1_dsp_arb_if.slave (requests, operands, grants, acks,
//                shared results, DSP operand/result signals)
// Parameters:
//   DSP_LAT : DSP result latency in cycles, 1..4
//   RR_EN   : 1 = round-robin on contention, 0 = ALU always wins
// Optional feature macro N1_DSP_ARB_LOCK_EN: adds bus.lock_i, letting a
// granted requester keep the DSP across consecutive cycles.
// -----------------------------------------------------------------------------
module n1_dsp_arb
    import n1_dsp_arb_pkg::*;
#(
    parameter int DSP_LAT = 1,
    parameter bit RR_EN   = 1'b1
) (
    input  logic        clk_i,
    input  logic        sync_rst_i,
    n1_dsp_arb_if.slave bus
);

    dsp_req_t alu_req;
    dsp_req_t pagu_req;
    dsp_req_t dsp_req;
    req_id_t  ptr_q;        // requester that wins the next tie
    logic     gnt_valid;
    req_id_t  gnt_id;
    tag_t     issue_tag;
    logic     alu_ack;
    logic     pagu_ack;

    assign alu_req = '{
        sub_add_b:   bus.alu_sub_add_b_i,
        smul_umul_b: bus.alu_smul_umul_b_i,
        add_op0:     bus.alu_add_op0_i,
        add_op1:     bus.alu_add_op1_i,
        mul_op0:     bus.alu_mul_op0_i,
        mul_op1:     bus.alu_mul_op1_i
    };

    assign pagu_req = '{
        sub_add_b:   bus.pagu_sub_add_b_i,
        smul_umul_b: bus.pagu_smul_umul_b_i,
        add_op0:     bus.pagu_add_op0_i,
        add_op1:     bus.pagu_add_op1_i,
        mul_op0:     bus.pagu_mul_op0_i,
        mul_op1:     bus.pagu_mul_op1_i
    };

`ifdef N1_DSP_ARB_LOCK_EN
    logic    lock_q;
    req_id_t lock_owner_q;
    logic    lock_hold;

    // A lock only sticks while its owner keeps requesting; dropping req
    // releases it in the same cycle.
    assign lock_hold = lock_q &&
                       ((lock_owner_q == PAGU) ? bus.pagu_req_i : bus.alu_req_i);
`endif

    // Grant decision. Nothing is granted while reset is held.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        gnt_valid = 1'b0;
        gnt_id    = ALU;
        if (!sync_rst_i) begin
            if (bus.alu_req_i && bus.pagu_req_i) begin
                gnt_valid = 1'b1;
                if (RR_EN) begin
                    gnt_id = ptr_q;
                end else begin
                    gnt_id = ALU;
                end
            end else if (bus.alu_req_i) begin
                gnt_valid = 1'b1;
                gnt_id    = ALU;
            end else if (bus.pagu_req_i) begin
                gnt_valid = 1'b1;
                gnt_id    = PAGU;
            end
`ifdef N1_DSP_ARB_LOCK_EN
            // The owner is requesting here, so gnt_valid is already set.
            if (lock_hold) begin
                gnt_id = lock_owner_q;
            end
`endif
        end
    end

    // After any grant the other requester becomes the favourite.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            ptr_q <= ALU;
        end else if (gnt_valid) begin
            ptr_q <= other_req(gnt_id);
        end
    end

`ifdef N1_DSP_ARB_LOCK_EN
    // lock_i is only meaningful alongside a grant; a cycle without a grant
    // always clears the lock.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            lock_q       <= 1'b0;
            lock_owner_q <= ALU;
        end else begin
            lock_q <= gnt_valid && bus.lock_i;
            if (gnt_valid) begin
                lock_owner_q <= gnt_id;
            end
        end
    end
`endif

    // Operand mux: an idle DSP sees +0 and unsigned *0.
    always_comb begin
        dsp_req = '0;
        if (gnt_valid) begin
            dsp_req = (gnt_id == PAGU) ? pagu_req : alu_req;
        end
    end

    assign bus.alu_gnt_o  = gnt_valid && (gnt_id == ALU);
    assign bus.pagu_gnt_o = gnt_valid && (gnt_id == PAGU);

    assign bus.arb2dsp_sub_add_b_o   = dsp_req.sub_add_b;
    assign bus.arb2dsp_smul_umul_b_o = dsp_req.smul_umul_b;
    assign bus.arb2dsp_add_op0_o     = dsp_req.add_op0;
    assign bus.arb2dsp_add_op1_o     = dsp_req.add_op1;
    assign bus.arb2dsp_mul_op0_o     = dsp_req.mul_op0;
    assign bus.arb2dsp_mul_op1_o     = dsp_req.mul_op1;

    assign issue_tag = '{valid: gnt_valid, owner: gnt_id};

    n1_dsp_arb_tagpipe #(
        .DSP_LAT (DSP_LAT)
    ) u_tagpipe (
        .clk_i       (clk_i),
        .sync_rst_i  (sync_rst_i),
        .issue_tag_i (issue_tag),
        .alu_ack_o   (alu_ack),
        .pagu_ack_o  (pagu_ack)
    );

    assign bus.alu_ack_o  = alu_ack;
    assign bus.pagu_ack_o = pagu_ack;

    // Results pass through only in an ack cycle so requesters never see
    // another requester's or a flushed operation's data.
    assign bus.arb2req_add_res_o = (alu_ack || pagu_ack) ? bus.dsp2arb_add_res_i : 32'h0;
    assign bus.arb2req_mul_res_o = (alu_ack || pagu_ack) ? bus.dsp2arb_mul_res_i : 32'h0;

endmodule

// File: tb/tb_n1_dsp_arb.sv
// -----------------------------------------------------------------------------
// tb_n1_dsp_arb
// Three arbiter instances share one stimulus stream:
//   cfg0: DSP_LAT=1, round-robin
//   cfg1: DSP_LAT=3, fixed priority (ALU highest)
//   cfg2: DSP_LAT=2, round-robin
// Each instance has its own behavioural DSP (delay line of add/mul results).
// A reference model predicts grants, DSP operands, acks and results for every
// instance every cycle; directed tasks add spot checks from worked examples.
// Define N1_DSP_ARB_LOCK_EN to exercise the lock feature as well.
// -----------------------------------------------------------------------------
module tb_n1_dsp_arb;
    import n1_dsp_arb_pkg::*;

    localparam int NCFG = 3;

    logic     clk = 1'b0;
    logic     rst;
    logic     alu_req;
    logic     pagu_req;
    dsp_req_t alu_s;
    dsp_req_t pagu_s;
`ifdef N1_DSP_ARB_LOCK_EN
    logic     lock;
`endif

    always #5 clk = ~clk;

    // DUT outputs gathered per configuration
    logic        o_alu_gnt  [NCFG];
    logic        o_pagu_gnt [NCFG];
    logic        o_alu_ack  [NCFG];
    logic        o_pagu_ack [NCFG];
    logic [31:0] o_add_res  [NCFG];
    logic [31:0] o_mul_res  [NCFG];
    dsp_req_t    o_dsp      [NCFG];

    // What the DSP cell computes, from its operands.
    function automatic logic [31:0] calc_add(input logic sub, input logic [15:0] op0,
                                             input logic [15:0] op1);
        logic [31:0] a;
        logic [31:0] b;
        a = {16'h0, op1};
        b = {16'h0, op0};
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic [31:0] calc_mul(input logic sgn, input logic [15:0] op0,
                                             input logic [15:0] op1);
        logic [31:0] a;
        logic [31:0] b;
        if (sgn) begin
            a = {{16{op1[15]}}, op1};
            b = {{16{op0[15]}}, op0};
        end else begin
            a = {16'h0, op1};
            b = {16'h0, op0};
        end
        return a * b;
    endfunction

    function automatic int cfg_lat(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic bit cfg_rr(input int k);
        return (k != 1);
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam bit RR  = (g != 1);

        n1_dsp_arb_if bus ();

        assign bus.alu_req_i          = alu_req;
        assign bus.alu_sub_add_b_i    = alu_s.sub_add_b;
        assign bus.alu_smul_umul_b_i  = alu_s.smul_umul_b;
        assign bus.alu_add_op0_i      = alu_s.add_op0;
        assign bus.alu_add_op1_i      = alu_s.add_op1;
        assign bus.alu_mul_op0_i      = alu_s.mul_op0;
        assign bus.alu_mul_op1_i      = alu_s.mul_op1;
        assign bus.pagu_req_i         = pagu_req;
        assign bus.pagu_sub_add_b_i   = pagu_s.sub_add_b;
        assign bus.pagu_smul_umul_b_i = pagu_s.smul_umul_b;
        assign bus.pagu_add_op0_i     = pagu_s.add_op0;
        assign bus.pagu_add_op1_i     = pagu_s.add_op1;
        assign bus.pagu_mul_op0_i     = pagu_s.mul_op0;
        assign bus.pagu_mul_op1_i     = pagu_s.mul_op1;
`ifdef N1_DSP_ARB_LOCK_EN
        assign bus.lock_i             = lock;
`endif

        n1_dsp_arb #(
            .DSP_LAT (LAT),
            .RR_EN   (RR)
        ) u_dut (
            .clk_i      (clk),
            .sync_rst_i (rst),
            .bus        (bus)
        );

        assign o_alu_gnt[g]  = bus.alu_gnt_o;
        assign o_pagu_gnt[g] = bus.pagu_gnt_o;
        assign o_alu_ack[g]  = bus.alu_ack_o;
        assign o_pagu_ack[g] = bus.pagu_ack_o;
        assign o_add_res[g]  = bus.arb2req_add_res_o;
        assign o_mul_res[g]  = bus.arb2req_mul_res_o;
        assign o_dsp[g] = '{
            sub_add_b:   bus.arb2dsp_sub_add_b_o,
            smul_umul_b: bus.arb2dsp_smul_umul_b_o,
            add_op0:     bus.arb2dsp_add_op0_o,
            add_op1:     bus.arb2dsp_add_op1_o,
            mul_op0:     bus.arb2dsp_mul_op0_o,
            mul_op1:     bus.arb2dsp_mul_op1_o
        };

        // Behavioural DSP cell: results appear LAT cycles after the operands.
        logic [31:0] add_pipe [LAT];
        logic [31:0] mul_pipe [LAT];
        always @(posedge clk) begin
            add_pipe[0] <= calc_add(o_dsp[g].sub_add_b, o_dsp[g].add_op0, o_dsp[g].add_op1);
            mul_pipe[0] <= calc_mul(o_dsp[g].smul_umul_b, o_dsp[g].mul_op0, o_dsp[g].mul_op1);
            for (int i = 1; i < LAT; i++) begin
                add_pipe[i] <= add_pipe[i-1];
                mul_pipe[i] <= mul_pipe[i-1];
            end
        end
        assign bus.dsp2arb_add_res_i = add_pipe[LAT-1];
        assign bus.dsp2arb_mul_res_i = mul_pipe[LAT-1];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          owner;   // 0 = ALU, 1 = PAGU
        logic [31:0] add_res;
        logic [31:0] mul_res;
    } exp_t;

    exp_t exp_q [NCFG][$];
    int   favour   [NCFG];    // who wins the next tie
    bit   lock_on  [NCFG];
    int   lock_who [NCFG];
    int   cyc;
    int   checks;
    int   errors;

    // Outputs observed in the most recent cycle, for directed spot checks.
    logic        snap_alu_gnt  [NCFG];
    logic        snap_pagu_gnt [NCFG];
    logic        snap_alu_ack  [NCFG];
    logic        snap_pagu_ack [NCFG];
    logic [31:0] snap_add      [NCFG];
    logic [31:0] snap_mul      [NCFG];

    function automatic dsp_req_t rand_req();
        dsp_req_t r;
        r.sub_add_b   = 1'($urandom_range(0, 1));
        r.smul_umul_b = 1'($urandom_range(0, 1));
        r.add_op0     = 16'($urandom);
        r.add_op1     = 16'($urandom);
        r.mul_op0     = 16'($urandom);
        r.mul_op1     = 16'($urandom);
        return r;
    endfunction

    // One clock cycle: compare every instance against the model mid-cycle,
    // advance the model, then step past the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            bit          any;
            int          win;
            bit          e_ag, e_pg, e_aa, e_pa;
            dsp_req_t    e_dsp;
            dsp_req_t    win_s;
            logic [31:0] e_add, e_mul;

            any = 1'b0;
            win = 0;
            if (!rst && (alu_req || pagu_req)) begin
                any = 1'b1;
                if (alu_req && pagu_req) win = cfg_rr(k) ? favour[k] : 0;
                else                     win = pagu_req ? 1 : 0;
`ifdef N1_DSP_ARB_LOCK_EN
                if (lock_on[k] && ((lock_who[k] == 1) ? pagu_req : alu_req)) win = lock_who[k];
`endif
            end
            e_ag  = any && (win == 0);
            e_pg  = any && (win == 1);
            win_s = (win == 1) ? pagu_s : alu_s;
            e_dsp = any ? win_s : '0;

            e_aa  = 1'b0;
            e_pa  = 1'b0;
            e_add = 32'h0;
            e_mul = 32'h0;
            if (!rst && exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
                exp_t e;
                e     = exp_q[k].pop_front();
                e_aa  = (e.owner == 0);
                e_pa  = (e.owner == 1);
                e_add = e.add_res;
                e_mul = e.mul_res;
            end

            checks++;
            if (o_alu_gnt[k] !== e_ag || o_pagu_gnt[k] !== e_pg) begin
                errors++;
                $display("FAIL cfg%0d cyc%0d gnt: got alu=%b pagu=%b, want alu=%b pagu=%b",
                         k, cyc, o_alu_gnt[k], o_pagu_gnt[k], e_ag, e_pg);
            end
            checks++;
            if (o_dsp[k] !== e_dsp) begin
                errors++;
                $display("FAIL cfg%0d cyc%0d arb2dsp: got %h, want %h", k, cyc, o_dsp[k], e_dsp);
            end
            checks++;
            if (o_alu_ack[k] !== e_aa || o_pagu_ack[k] !== e_pa) begin
                errors++;
                $display("FAIL cfg%0d cyc%0d ack: got alu=%b pagu=%b, want alu=%b pagu=%b",
                         k, cyc, o_alu_ack[k], o_pagu_ack[k], e_aa, e_pa);
            end
            checks++;
            if (o_add_res[k] !== e_add || o_mul_res[k] !== e_mul) begin
                errors++;
                $display("FAIL cfg%0d cyc%0d result: got add=%h mul=%h, want add=%h mul=%h",
                         k, cyc, o_add_res[k], o_mul_res[k], e_add, e_mul);
            end

            snap_alu_gnt[k]  = o_alu_gnt[k];
            snap_pagu_gnt[k] = o_pagu_gnt[k];
            snap_alu_ack[k]  = o_alu_ack[k];
            snap_pagu_ack[k] = o_pagu_ack[k];
            snap_add[k]      = o_add_res[k];
            snap_mul[k]      = o_mul_res[k];

            if (rst) begin
                exp_q[k].delete();
                favour[k]  = 0;
                lock_on[k] = 1'b0;
            end else if (any) begin
                exp_q[k].push_back('{due: cyc + cfg_lat(k), owner: win,
                                     add_res: calc_add(win_s.sub_add_b, win_s.add_op0, win_s.add_op1),
                                     mul_res: calc_mul(win_s.smul_umul_b, win_s.mul_op0, win_s.mul_op1)});
                favour[k]   = 1 - win;
                lock_who[k] = win;
`ifdef N1_DSP_ARB_LOCK_EN
                lock_on[k]  = lock;
`endif
            end else begin
                lock_on[k] = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_req  = 1'b0;
        pagu_req = 1'b0;
`ifdef N1_DSP_ARB_LOCK_EN
        lock     = 1'b0;
`endif
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst      = 1'b1;
        alu_req  = 1'b1;
        pagu_req = 1'b1;
        run_cycle();
        for (int k = 0; k < NCFG; k++) begin
            checks++;
            if (snap_alu_gnt[k] !== 1'b0 || snap_pagu_gnt[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_grant cfg%0d: got alu=%b pagu=%b, want 0 0",
                         k, snap_alu_gnt[k], snap_pagu_gnt[k]);
            end
        end
        rst = 1'b0;
        idle();
        run_cycle();
        for (int k = 0; k < NCFG; k++) begin
            checks++;
            if (snap_alu_ack[k] !== 1'b0 || snap_pagu_ack[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_ack cfg%0d: got alu=%b pagu=%b, want 0 0",
                         k, snap_alu_ack[k], snap_pagu_ack[k]);
            end
        end
    endtask

    task automatic test_alu_alone();
        alu_s             = rand_req();
        alu_s.sub_add_b   = 1'b1;
        alu_s.add_op1     = 16'h1234;
        alu_s.add_op0     = 16'h0001;
        alu_req           = 1'b1;
        run_cycle();
        checks++;
        if (snap_alu_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL alu_alone_gnt: got %b, want 1", snap_alu_gnt[0]);
        end
        alu_req = 1'b0;
        run_cycle();
        checks++;
        if (snap_alu_ack[0] !== 1'b1 || snap_pagu_ack[0] !== 1'b0 || snap_add[0] !== 32'h0000_1233) begin
            errors++;
            $display("FAIL alu_alone_ack: got alu_ack=%b pagu_ack=%b add=%h, want 1 0 00001233",
                     snap_alu_ack[0], snap_pagu_ack[0], snap_add[0]);
        end
        drain(4);
    endtask

    task automatic test_round_robin();
        reset_dut();
        alu_s    = rand_req();
        pagu_s   = rand_req();
        alu_req  = 1'b1;
        pagu_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            checks++;
            if (snap_alu_gnt[0] !== (i % 2 == 0) || snap_pagu_gnt[0] !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_order step%0d: got alu=%b pagu=%b, want alu=%b pagu=%b",
                         i, snap_alu_gnt[0], snap_pagu_gnt[0], (i % 2 == 0), (i % 2 == 1));
            end
            checks++;
            if (snap_alu_gnt[1] !== 1'b1 || snap_pagu_gnt[1] !== 1'b0) begin
                errors++;
                $display("FAIL fixed_prio step%0d: got alu=%b pagu=%b, want 1 0",
                         i, snap_alu_gnt[1], snap_pagu_gnt[1]);
            end
            if (i > 0) begin
                checks++;
                if (snap_alu_ack[0] !== ((i - 1) % 2 == 0) || snap_pagu_ack[0] !== ((i - 1) % 2 == 1)) begin
                    errors++;
                    $display("FAIL rr_ack_order step%0d: got alu=%b pagu=%b", i,
                             snap_alu_ack[0], snap_pagu_ack[0]);
                end
            end
        end
        alu_req = 1'b0;
        run_cycle();
        checks++;
        if (snap_pagu_gnt[1] !== 1'b1 || snap_pagu_ack[0] !== 1'b1) begin
            errors++;
            $display("FAIL alu_drop: got cfg1 pagu_gnt=%b cfg0 pagu_ack=%b, want 1 1",
                     snap_pagu_gnt[1], snap_pagu_ack[0]);
        end
        drain(4);
    endtask

    task automatic test_back_to_back();
        alu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_s = rand_req();
            run_cycle();
            for (int k = 0; k < NCFG; k++) begin
                checks++;
                if (snap_alu_gnt[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gnt cfg%0d step%0d: got %b, want 1", k, i, snap_alu_gnt[k]);
                end
            end
        end
        drain(4);
    endtask

    task automatic test_latency3();
        pagu_s             = rand_req();
        pagu_s.smul_umul_b = 1'b0;
        pagu_s.mul_op1     = 16'hFFFF;
        pagu_s.mul_op0     = 16'h0002;
        pagu_req           = 1'b1;
        run_cycle();                       // t
        pagu_req           = 1'b0;
        alu_s              = rand_req();
        alu_s.smul_umul_b  = 1'b1;
        alu_s.mul_op1      = 16'hFFFF;
        alu_s.mul_op0      = 16'h0002;
        alu_req            = 1'b1;
        run_cycle();                       // t+1
        idle();
        run_cycle();                       // t+2
        run_cycle();                       // t+3
        checks++;
        if (snap_pagu_ack[1] !== 1'b1 || snap_alu_ack[1] !== 1'b0 || snap_mul[1] !== 32'h0001_FFFE) begin
            errors++;
            $display("FAIL lat3_pagu: got pagu_ack=%b alu_ack=%b mul=%h, want 1 0 0001fffe",
                     snap_pagu_ack[1], snap_alu_ack[1], snap_mul[1]);
        end
        run_cycle();                       // t+4
        checks++;
        if (snap_alu_ack[1] !== 1'b1 || snap_pagu_ack[1] !== 1'b0 || snap_mul[1] !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL lat3_alu: got alu_ack=%b pagu_ack=%b mul=%h, want 1 0 fffffffe",
                     snap_alu_ack[1], snap_pagu_ack[1], snap_mul[1]);
        end
        drain(3);
    endtask

    task automatic test_reset_mid_op();
        alu_s   = rand_req();
        alu_req = 1'b1;
        run_cycle();                       // grant at t
        checks++;
        if (snap_alu_gnt[2] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt: got %b, want 1", snap_alu_gnt[2]);
        end
        idle();
        rst = 1'b1;
        run_cycle();                       // t+1 in reset
        rst = 1'b0;
        run_cycle();                       // t+2, ack would have been due
        checks++;
        if (snap_alu_ack[2] !== 1'b0 || snap_pagu_ack[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ack: got alu=%b pagu=%b, want 0 0", snap_alu_ack[2], snap_pagu_ack[2]);
        end
        alu_s    = rand_req();
        pagu_s   = rand_req();
        alu_req  = 1'b1;
        pagu_req = 1'b1;
        run_cycle();
        checks++;
        if (snap_alu_gnt[2] !== 1'b1 || snap_pagu_gnt[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ptr: got alu=%b pagu=%b, want 1 0", snap_alu_gnt[2], snap_pagu_gnt[2]);
        end
        drain(4);
    endtask

`ifdef N1_DSP_ARB_LOCK_EN
    task automatic test_lock();
        reset_dut();
        alu_s    = rand_req();
        pagu_s   = rand_req();
        alu_req  = 1'b1;
        pagu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lock = (i < 2);
            run_cycle();
            checks++;
            if (snap_alu_gnt[0] !== 1'b1 || snap_pagu_gnt[0] !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold step%0d: got alu=%b pagu=%b, want 1 0",
                         i, snap_alu_gnt[0], snap_pagu_gnt[0]);
            end
        end
        lock = 1'b0;
        run_cycle();
        checks++;
        if (snap_pagu_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL lock_release: got pagu_gnt=%b, want 1", snap_pagu_gnt[0]);
        end
        drain(4);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!alu_req || snap_alu_gnt[0]) begin
                alu_req = ($urandom_range(0, 9) < 6);
                alu_s   = rand_req();
            end else if ($urandom_range(0, 9) == 0) begin
                alu_req = 1'b0;
            end
            if (!pagu_req || snap_pagu_gnt[0]) begin
                pagu_req = ($urandom_range(0, 9) < 6);
                pagu_s   = rand_req();
            end else if ($urandom_range(0, 9) == 0) begin
                pagu_req = 1'b0;
            end
`ifdef N1_DSP_ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            run_cycle();
        end
        rst = 1'b0;
        drain(5);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst      = 1'b1;
        alu_s    = '0;
        pagu_s   = '0;
        idle();
        for (int k = 0; k < NCFG; k++) begin
            favour[k]        = 0;
            lock_on[k]       = 1'b0;
            lock_who[k]      = 0;
            snap_alu_gnt[k]  = 1'b0;
            snap_pagu_gnt[k] = 1'b0;
        end
        @(posedge clk);
        #1;

        test_reset();
        test_alu_alone();
        test_round_robin();
        test_back_to_back();
        test_latency3();
        test_reset_mid_op();
`ifdef N1_DSP_ARB_LOCK_EN
        test_lock();
`endif
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/n1_dsp_arb.md
Name: N1_dsp_arb

Overview:
- Arbitrates the single DSP cell (adder/subtractor plus multiplier) between two requesters: the ALU (requester 0) and the program address generation unit, PAGU (requester 1).
- Muxes each requester's operands onto the DSP inputs.
- Tracks in-flight operations through the DSP pipeline.
- Returns each result, with a one-cycle acknowledge, to the requester that issued it.
- Sits between the N1 core and the target-specific DSP wrapper.

Parameters:
- DSP_LAT, 1, DSP result latency in cycles (1..4).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with ALU highest.

Ports:
- clk_i  in  1  system clock
- sync_rst_i  in  1  synchronous reset, active-high
- alu_req_i, pagu_req_i  in  1  request; held until granted
- alu_gnt_o, pagu_gnt_o  out  1  grant; combinational, same cycle as the request
- alu_sub_add_b_i, pagu_sub_add_b_i  in  1  1: op1 - op0, 0: op1 + op0
- alu_smul_umul_b_i, pagu_smul_umul_b_i  in  1  1: signed multiply, 0: unsigned
- alu_add_op0_i/op1_i, pagu_add_op0_i/op1_i  in  16  adder operands
- alu_mul_op0_i/op1_i, pagu_mul_op0_i/op1_i  in  16  multiplier operands
- alu_ack_o, pagu_ack_o  out  1  result-valid pulse
- arb2req_add_res_o  out  32  adder result, shared, valid with ack
- arb2req_mul_res_o  out  32  multiplier result, shared, valid with ack
- arb2dsp_sub_add_b_o, arb2dsp_smul_umul_b_o  out  1  to DSP
- arb2dsp_add_op0_o/op1_o, arb2dsp_mul_op0_o/op1_o  out  16  to DSP
- dsp2arb_add_res_i, dsp2arb_mul_res_i  in  32  from DSP, DSP_LAT cycles after the operands
- lock_i  in  1  only with N1_DSP_ARB_LOCK_EN

Behaviour:
- Clock and reset: single clock clk_i; reset sync_rst_i is synchronous and active-high.
- Reset state:
  - Priority pointer = 0 (ALU).
  - Tag pipeline all invalid.
  - All acks 0.
  - No grant until the first request after reset is deasserted.
- Issue and grant:
  - Every cycle with at least one request, exactly one grant is asserted; at most one grant per cycle.
  - The granted requester's operands and mode bits are driven onto arb2dsp_*.
  - With no grant, all arb2dsp_* outputs = 0 (DSP sees +0 and *0 unsigned).
- Arbitration:
  - Round-robin: on a simultaneous request, the requester indicated by the pointer wins. After any grant the pointer moves to the non-granted requester.
  - A single requester is granted every cycle (back-to-back issue, full throughput).
  - RR_EN=0: the ALU always wins.
- Tag pipeline:
  - A DSP_LAT-deep shift register holds {valid, owner}, loaded at grant.
  - When the stage-DSP_LAT entry is valid, the owner's ack pulses for one cycle. arb2req_add_res_o and arb2req_mul_res_o then pass dsp2arb_* through unchanged.
  - Otherwise the result outputs are 0.
- Latency: grant at cycle t -> ack at t+DSP_LAT.
- Concurrency: up to DSP_LAT operations are in flight, mixed owners allowed. Acks arrive in issue order; both acks are never high in the same cycle.
- Request/grant in the same cycle as an ack: independent; both happen.
- Reset mid-operation: all in-flight tags are invalidated, no ack is generated for them, and the pointer returns to 0.
- Requester obligation: hold req and operands stable until gnt. Deasserting req before gnt is legal and withdraws the request; no result is produced.

Optional Feature:
- Macro N1_DSP_ARB_LOCK_EN.
- Defined:
  - lock_i is sampled with a grant. If high, the current owner keeps ownership for following cycles while its req stays high; the other requester is blocked.
  - The lock releases when lock_i is low at a grant or when the owner drops req.
  - Used for ALU multi-cycle sequences (e.g. UM* then carry add).
- Undefined: lock_i port absent; arbitration is purely per cycle.

Decomposition:
- Package N1_dsp_arb_pkg:
  - typedef req_id_t (1-bit enum ALU=0, PAGU=1).
  - struct dsp_req_t {sub_add_b, smul_umul_b, add_op0, add_op1, mul_op0, mul_op1}.
  - struct tag_t {valid, owner}.
  - localparam MAX_DSP_LAT=4.
- Sub-module N1_dsp_arb_tagpipe: DSP_LAT-deep tag shift register with synchronous reset, producing the ack pulses.

Test Plan:
- ALU alone, add_op1=0x1234, add_op0=0x0001, sub=1, DSP_LAT=1 -> alu_gnt same cycle; alu_ack next cycle; add_res=0x00001233; pagu_ack=0.
- Both requesting for 4 cycles, RR_EN=1 -> grants ALU, PAGU, ALU, PAGU; acks follow in the same order, 1 cycle later.
- RR_EN=0, both requesting -> ALU granted every cycle, pagu_gnt=0 until alu_req drops.
- DSP_LAT=3, PAGU mul 0xFFFF*0x0002 unsigned at t, ALU signed mul at t+1 -> pagu_ack at t+3 with mul_res=0x0001FFFE; alu_ack at t+4 with mul_res=0xFFFFFFFE.
- sync_rst_i asserted 1 cycle after a grant (DSP_LAT=2) -> no ack ever for that operation; the next simultaneous request is granted to the ALU.
- LOCK_EN: ALU granted with lock_i=1 while PAGU requests for 3 cycles -> ALU granted 3 cycles; PAGU granted the cycle after lock_i=0.
